// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage sitting directly upstream of the control unit.
// It owns the program counter, issues a read to the instruction ROM
// whenever the control unit asks for one, waits out the ROM's fixed read
// latency, and captures the returned word into REG_IR for decoding.
// The PC is sequenced by control-unit strobes and is fully independent of
// fetch timing.
//
// Parameters
//   PC_WIDTH     width of the PC and the ROM address
//   IR_WIDTH     width of the instruction word / REG_IR
//   ROM_LATENCY  edges from the ROM sampling romEn/romAddr until romData
//                is valid (legal range 1..7)
//
// Ports
//   Clk        in   system clock, rising edge active
//   nReset     in   asynchronous active-low reset
//   iROMREAD   in   fetch request, level-sampled every edge
//   pcINC      in   PC <- PC + 1
//   pcRST      in   PC <- 0 (highest priority)
//   pcLOAD     in   PC <- pcLoadVal (beats pcINC)
//   pcLoadVal  in   jump target from the data bus
//   romAddr    out  registered ROM address, held until the next fetch
//   romEn      out  registered ROM read enable, one-cycle pulse per fetch
//   romData    in   ROM read data
//   REG_IR     out  instruction register
//   irValid    out  one-cycle pulse when REG_IR is updated
//   busy       out  high while a fetch is outstanding
//   missedReq  out  one-cycle pulse when a request arrives while busy
//   PC         out  current program counter
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int IR_WIDTH    = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                iROMREAD,
  input  logic                pcINC,
  input  logic                pcRST,
  input  logic                pcLOAD,
  input  logic [PC_WIDTH-1:0] pcLoadVal,
  output logic [PC_WIDTH-1:0] romAddr,
  output logic                romEn,
  input  logic [IR_WIDTH-1:0] romData,
  output logic [IR_WIDTH-1:0] REG_IR,
  output logic                irValid,
  output logic                busy,
  output logic                missedReq,
  output logic [PC_WIDTH-1:0] PC
);

  // A 3-bit wait counter covers the whole 1..7 latency range.
  localparam int            CW       = 3;
  localparam logic [CW-1:0] LAT_INIT = CW'(ROM_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;

  // Fetch sequencer. The counter is loaded with ROM_LATENCY on the accept
  // edge and counted down in WAIT; the capture happens on the edge where
  // it already reads zero, which yields ROM_LATENCY+1 edges from request
  // to capture. The extra edge is the one the ROM spends sampling romEn.
  // Requests seen in WAIT, including on the capture edge, are dropped and
  // flagged so the control unit knows to retry.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      romAddr   <= '0;
      romEn     <= 1'b0;
      REG_IR    <= '0;
      irValid   <= 1'b0;
      busy      <= 1'b0;
      missedReq <= 1'b0;
      waitCnt   <= '0;
    end else begin
      romEn     <= 1'b0;
      irValid   <= 1'b0;
      missedReq <= 1'b0;
      case (state)
        IDLE: begin
          if (iROMREAD) begin
            // The pre-update PC is latched even if a PC strobe
            // fires on this same edge.
            romAddr <= PC;
            romEn   <= 1'b1;
            busy    <= 1'b1;
            waitCnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          missedReq <= iROMREAD;
          if (waitCnt == '0) begin
            REG_IR  <= romData;
            irValid <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            waitCnt <= waitCnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter. Runs every edge in parallel with the fetch sequencer
  // so jumps and increments never wait on the ROM. Wraps silently.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      PC <= '0;
    end else if (pcRST) begin
      PC <= '0;
    end else if (pcLOAD) begin
      PC <= pcLoadVal;
    end else if (pcINC) begin
      PC <= PC + PC_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. Provides a latency-accurate ROM model, a
// transaction-level reference model of the fetch unit, a table of directed
// vectors, hand-written multi-cycle sequences and a randomized phase.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int PW  = 8;
  localparam int IW  = 8;
  localparam int LAT = 2;

  logic          Clk = 1'b0;
  logic          nReset;
  logic          iROMREAD;
  logic          pcINC;
  logic          pcRST;
  logic          pcLOAD;
  logic [PW-1:0] pcLoadVal;
  logic [PW-1:0] romAddr;
  logic          romEn;
  logic [IW-1:0] romData;
  logic [IW-1:0] REG_IR;
  logic          irValid;
  logic          busy;
  logic          missedReq;
  logic [PW-1:0] PC;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(
    .PC_WIDTH   (PW),
    .IR_WIDTH   (IW),
    .ROM_LATENCY(LAT)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .iROMREAD (iROMREAD),
    .pcINC    (pcINC),
    .pcRST    (pcRST),
    .pcLOAD   (pcLOAD),
    .pcLoadVal(pcLoadVal),
    .romAddr  (romAddr),
    .romEn    (romEn),
    .romData  (romData),
    .REG_IR   (REG_IR),
    .irValid  (irValid),
    .busy     (busy),
    .missedReq(missedReq),
    .PC       (PC)
  );

  // ROM model: samples romEn/romAddr on an edge and presents the word LAT
  // edges later. Any cycle without a real read pushes random garbage, so a
  // capture at the wrong moment picks up a wrong word.
  logic [IW-1:0] rom     [0:255];
  logic [IW-1:0] romPipe [0:LAT-1];

  always @(posedge Clk) begin
    romPipe[0] <= romEn ? rom[romAddr] : IW'($urandom);
    for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
  end

  assign romData = romPipe[LAT-1];

  // Reference model: a fetch is either outstanding or not; an accepted
  // fetch completes LAT+1 edges later with the word at its address.
  logic [PW-1:0] mPC, mRomAddr;
  logic [IW-1:0] mIR;
  bit            mRomEn, mBusy, mValid, mMissed, mPending;
  int            mLeft;

  task automatic modelReset();
    mPC = '0; mRomAddr = '0; mIR = '0;
    mRomEn = 0; mBusy = 0; mValid = 0; mMissed = 0; mPending = 0; mLeft = 0;
  endtask

  task automatic modelEdge();
    if (!nReset) begin
      modelReset();
      return;
    end
    mRomEn = 0; mValid = 0; mMissed = 0;
    if (mPending) begin
      if (iROMREAD) mMissed = 1;
      mLeft--;
      if (mLeft == 0) begin
        mIR      = rom[mRomAddr];
        mValid   = 1;
        mPending = 0;
      end
    end else if (iROMREAD) begin
      mRomAddr = mPC;
      mRomEn   = 1;
      mPending = 1;
      mLeft    = LAT + 1;
    end
    if (pcRST)       mPC = '0;
    else if (pcLOAD) mPC = pcLoadVal;
    else if (pcINC)  mPC = mPC + 8'd1;
    mBusy = mPending;
  endtask

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".PC"},        32'(PC),        32'(mPC));
    checkVal({tag, ".romAddr"},   32'(romAddr),   32'(mRomAddr));
    checkVal({tag, ".romEn"},     32'(romEn),     32'(mRomEn));
    checkVal({tag, ".REG_IR"},    32'(REG_IR),    32'(mIR));
    checkVal({tag, ".irValid"},   32'(irValid),   32'(mValid));
    checkVal({tag, ".busy"},      32'(busy),      32'(mBusy));
    checkVal({tag, ".missedReq"}, 32'(missedReq), 32'(mMissed));
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, ".zero.PC"},        32'(PC),        0);
    checkVal({tag, ".zero.romAddr"},   32'(romAddr),   0);
    checkVal({tag, ".zero.romEn"},     32'(romEn),     0);
    checkVal({tag, ".zero.REG_IR"},    32'(REG_IR),    0);
    checkVal({tag, ".zero.irValid"},   32'(irValid),   0);
    checkVal({tag, ".zero.busy"},      32'(busy),      0);
    checkVal({tag, ".zero.missedReq"}, 32'(missedReq), 0);
  endtask

  // Drive one set of inputs for one edge, advance the model, compare.
  task automatic applyStimulus(input bit req, input bit inc, input bit rst,
                               input bit load, input logic [PW-1:0] val,
                               input string tag);
    @(negedge Clk);
    iROMREAD  = req;
    pcINC     = inc;
    pcRST     = rst;
    pcLOAD    = load;
    pcLoadVal = val;
    @(posedge Clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idleSteps(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00, tag);
  endtask

  typedef struct {
    bit            req, inc, rst, load;
    logic [PW-1:0] val;
    logic [PW-1:0] ePC;
    bit            eRomEn, eBusy, eValid, eMissed;
    bit            addrCare;
    logic [PW-1:0] eAddr;
    bit            irCare;
    logic [IW-1:0] eIR;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // PC sequencing, priority, then a request held for LAT+3 edges
    // (accepted, LAT+1 drops, accepted again on the first IDLE edge).
    vecs[0]  = '{0,0,0,1, 8'hFE, 8'hFE, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[1]  = '{0,1,0,0, 8'h00, 8'hFF, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[2]  = '{0,1,0,0, 8'h00, 8'h00, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[3]  = '{0,0,0,1, 8'h05, 8'h05, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[4]  = '{0,1,1,1, 8'h77, 8'h00, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[5]  = '{0,1,0,1, 8'h40, 8'h40, 0,0,0,0, 0,8'h00, 0,8'h00};
    vecs[6]  = '{1,0,0,0, 8'h00, 8'h40, 1,1,0,0, 1,8'h40, 0,8'h00};
    vecs[7]  = '{1,0,0,0, 8'h00, 8'h40, 0,1,0,1, 1,8'h40, 0,8'h00};
    vecs[8]  = '{1,0,0,0, 8'h00, 8'h40, 0,1,0,1, 1,8'h40, 0,8'h00};
    vecs[9]  = '{1,0,0,0, 8'h00, 8'h40, 0,0,1,1, 1,8'h40, 1,8'h3C};
    vecs[10] = '{1,0,0,0, 8'h00, 8'h40, 1,1,0,0, 1,8'h40, 0,8'h00};
    vecs[11] = '{0,0,0,0, 8'h00, 8'h40, 0,1,0,0, 1,8'h40, 0,8'h00};
    vecs[12] = '{0,0,0,0, 8'h00, 8'h40, 0,1,0,0, 1,8'h40, 0,8'h00};
    vecs[13] = '{0,0,0,0, 8'h00, 8'h40, 0,0,1,0, 1,8'h40, 1,8'h3C};

    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    rom[8'h00] = 8'h10;
    rom[8'h20] = 8'hA5;
    rom[8'h40] = 8'h3C;

    modelReset();
    nReset    = 1'b0;
    iROMREAD  = 1'b0;
    pcINC     = 1'b0;
    pcRST     = 1'b0;
    pcLOAD    = 1'b0;
    pcLoadVal = '0;

    // Reset held with random inputs, then three idle edges after release.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    PW'($urandom), "rstHold");
      checkZero("rstHold");
    end
    @(negedge Clk);
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 8'h00, "rstIdle");
      checkZero("rstIdle");
    end

    // Single fetch from address 0.
    applyStimulus(1, 0, 0, 0, 8'h00, "fetch.T");
    checkVal("fetch.T.romEn", 32'(romEn), 1);
    checkVal("fetch.T.romAddr", 32'(romAddr), 0);
    checkVal("fetch.T.busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 8'h00, "fetch.T1");
    checkVal("fetch.T1.romEn", 32'(romEn), 0);
    checkVal("fetch.T1.busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 8'h00, "fetch.T2");
    checkVal("fetch.T2.busy", 32'(busy), 1);
    checkVal("fetch.T2.irValid", 32'(irValid), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, "fetch.T3");
    checkVal("fetch.T3.REG_IR", 32'(REG_IR), 32'h10);
    checkVal("fetch.T3.irValid", 32'(irValid), 1);
    checkVal("fetch.T3.busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, "fetch.T4");
    checkVal("fetch.T4.irValid", 32'(irValid), 0);
    checkVal("fetch.T4.REG_IR", 32'(REG_IR), 32'h10);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].req, vecs[i].inc, vecs[i].rst, vecs[i].load,
                    vecs[i].val, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.PC", i),        32'(PC),        32'(vecs[i].ePC));
      checkVal($sformatf("vec%0d.romEn", i),     32'(romEn),     32'(vecs[i].eRomEn));
      checkVal($sformatf("vec%0d.busy", i),      32'(busy),      32'(vecs[i].eBusy));
      checkVal($sformatf("vec%0d.irValid", i),   32'(irValid),   32'(vecs[i].eValid));
      checkVal($sformatf("vec%0d.missedReq", i), 32'(missedReq), 32'(vecs[i].eMissed));
      if (vecs[i].addrCare)
        checkVal($sformatf("vec%0d.romAddr", i), 32'(romAddr), 32'(vecs[i].eAddr));
      if (vecs[i].irCare)
        checkVal($sformatf("vec%0d.REG_IR", i),  32'(REG_IR),  32'(vecs[i].eIR));
    end

    // PC change in the middle of a fetch.
    applyStimulus(0, 0, 0, 1, 8'h20, "mid.load20");
    applyStimulus(1, 0, 0, 0, 8'h00, "mid.req");
    checkVal("mid.req.romAddr", 32'(romAddr), 32'h20);
    applyStimulus(0, 0, 0, 1, 8'h80, "mid.load80");
    applyStimulus(0, 0, 0, 0, 8'h00, "mid.wait");
    applyStimulus(0, 0, 0, 0, 8'h00, "mid.cap");
    checkVal("mid.cap.REG_IR", 32'(REG_IR), 32'hA5);
    checkVal("mid.cap.irValid", 32'(irValid), 1);
    checkVal("mid.cap.PC", 32'(PC), 32'h80);
    checkVal("mid.cap.romAddr", 32'(romAddr), 32'h20);

    // Asynchronous reset between edges T+1 and T+2 of a fetch.
    applyStimulus(1, 0, 0, 0, 8'h00, "arst.T");
    applyStimulus(0, 0, 0, 0, 8'h00, "arst.T1");
    @(negedge Clk);
    iROMREAD = 1'b0;
    nReset   = 1'b0;
    modelReset();
    #1;
    checkZero("arst.async");
    @(negedge Clk);
    nReset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      applyStimulus(0, 0, 0, 0, 8'h00, "arst.after");
      checkVal("arst.after.irValid", 32'(irValid), 0);
    end
    applyStimulus(1, 0, 0, 0, 8'h00, "arst.newReq");
    idleSteps(LAT, "arst.newWait");
    applyStimulus(0, 0, 0, 0, 8'h00, "arst.newCap");
    checkVal("arst.newCap.irValid", 32'(irValid), 1);
    checkVal("arst.newCap.REG_IR", 32'(REG_IR), 32'h10);

    // Randomized phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) != 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 5) == 0,
                    PW'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
